// File: rtl/jtframe_bank_share.sv
// Two-slot round-robin sharer of a single SDRAM bank port.
// Write support is compiled in with `define JTFRAME_BANK_SHARE_WR_EN.
module jtframe_bank_share #(
   parameter int SDRAMW = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              downloading,
   input  logic [SDRAMW-1:0] slot0_addr,
   input  logic [SDRAMW-1:0] slot1_addr,
   input  logic              slot0_cs,
   input  logic              slot1_cs,
   input  logic              slot0_wr,
   input  logic              slot1_wr,
   input  logic [15:0]       slot0_din,
   input  logic [15:0]       slot1_din,
   input  logic [1:0]        slot0_dsn,
   input  logic [1:0]        slot1_dsn,
   output logic              slot0_ok,
   output logic              slot1_ok,
   output logic [15:0]       slot_dout,
   output logic [SDRAMW-1:0] ba_addr,
   output logic              ba_rd,
   output logic              ba_wr,
   output logic [15:0]       ba_din,
   output logic [1:0]        ba_dsn,
   input  logic              ba_ack,
   input  logic              ba_dst,
   input  logic              ba_dok,
   input  logic              ba_rdy,
   input  logic [15:0]       sdram_dout
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_t;

   state_t            st, st_nx;
   logic              last, last_nx;
   logic              gnt, gnt_nx;
   logic              rd_nx, wr_nx;
   logic              ok0_nx, ok1_nx;
   logic [SDRAMW-1:0] addr_nx;
   logic [15:0]       din_nx, dout_nx;
   logic [1:0]        dsn_nx;

   logic              req, sel, ok_now;
   logic [SDRAMW-1:0] sel_addr;
   logic              sel_wr;
   logic [15:0]       sel_din;
   logic [1:0]        sel_dsn;
   logic              unused_in;

   assign req    = slot0_cs | slot1_cs;
   assign ok_now = slot0_ok | slot1_ok;
   // When both ask, the slot not served last time wins
   assign sel    = (slot0_cs & slot1_cs) ? ~last : slot1_cs;

   assign sel_addr = sel ? slot1_addr : slot0_addr;

`ifdef JTFRAME_BANK_SHARE_WR_EN
   assign sel_wr  = sel ? slot1_wr  : slot0_wr;
   assign sel_din = sel ? slot1_din : slot0_din;
   assign sel_dsn = sel ? slot1_dsn : slot0_dsn;
   assign unused_in = ^{ba_dst, ba_dok};
`else
   assign sel_wr  = 1'b0;
   assign sel_din = 16'd0;
   assign sel_dsn = 2'b11;
   assign unused_in = ^{ba_dst, ba_dok, slot0_wr, slot1_wr,
                        slot0_din, slot1_din, slot0_dsn, slot1_dsn};
`endif

   always_comb begin
      st_nx   = st;
      last_nx = last;
      gnt_nx  = gnt;
      rd_nx   = ba_rd;
      wr_nx   = ba_wr;
      addr_nx = ba_addr;
      din_nx  = ba_din;
      dsn_nx  = ba_dsn;
      dout_nx = slot_dout;
      ok0_nx  = 1'b0;
      ok1_nx  = 1'b0;
      unique case (st)
         IDLE: begin
            // ok still high means the requester has not yet dropped cs
            if (req && !downloading && !ok_now) begin
               gnt_nx  = sel;
               addr_nx = sel_addr;
               din_nx  = sel_din;
               dsn_nx  = sel_dsn;
               rd_nx   = ~sel_wr;
               wr_nx   = sel_wr;
               st_nx   = CMD;
            end
         end
         CMD: begin
            if (ba_ack) begin
               rd_nx = 1'b0;
               wr_nx = 1'b0;
               if (ba_rdy) begin
                  dout_nx = sdram_dout;
                  ok0_nx  = ~gnt;
                  ok1_nx  = gnt;
                  last_nx = gnt;
                  st_nx   = IDLE;
               end else begin
                  st_nx = DATA;
               end
            end
         end
         DATA: begin
            if (ba_rdy) begin
               dout_nx = sdram_dout;
               ok0_nx  = ~gnt;
               ok1_nx  = gnt;
               last_nx = gnt;
               st_nx   = IDLE;
            end
         end
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         last      <= 1'b1;
         gnt       <= 1'b0;
         ba_rd     <= 1'b0;
         ba_wr     <= 1'b0;
         ba_addr   <= '0;
         ba_din    <= 16'd0;
         ba_dsn    <= 2'b11;
         slot_dout <= 16'd0;
         slot0_ok  <= 1'b0;
         slot1_ok  <= 1'b0;
      end else begin
         st        <= st_nx;
         last      <= last_nx;
         gnt       <= gnt_nx;
         ba_rd     <= rd_nx;
         ba_wr     <= wr_nx;
         ba_addr   <= addr_nx;
         ba_din    <= din_nx;
         ba_dsn    <= dsn_nx;
         slot_dout <= dout_nx;
         slot0_ok  <= ok0_nx;
         slot1_ok  <= ok1_nx;
      end
   end

endmodule
